// File: rtl/l1_meta_array_ctrl_if.sv
// Request/response bundle between the L1 metadata array controller and its
// read/write requesters. The requesters drive the master side.
interface l1_meta_array_ctrl_if #(
    parameter int NRD   = 4,
    parameter int NWR   = 2,
    parameter int NSETS = 64,
    parameter int NWAYS = 8,
    parameter int TAGW  = 20
);
    localparam int IDXW = $clog2(NSETS);
    localparam int IDW  = (NRD > 1) ? $clog2(NRD) : 1;

    logic [NRD-1:0]        rd_valid;
    logic [NRD-1:0]        rd_ready;
    logic [NRD*IDXW-1:0]   rd_idx;
    logic [NRD*TAGW-1:0]   rd_tag;

    logic [NWR-1:0]        wr_valid;
    logic [NWR-1:0]        wr_ready;
    logic [NWR*IDXW-1:0]   wr_idx;
    logic [NWR*NWAYS-1:0]  wr_way_en;
    logic [NWR*2-1:0]      wr_coh_state;
    logic [NWR*TAGW-1:0]   wr_tag;

    logic                  resp_valid;
    logic [IDW-1:0]        resp_id;
    logic [NWAYS*TAGW-1:0] resp_way_tag;
    logic [NWAYS*2-1:0]    resp_way_coh;
    logic [NWAYS-1:0]      resp_hit_way;
    logic                  resp_hit;
    logic                  init_done;

    modport master (
        output rd_valid, rd_idx, rd_tag,
        output wr_valid, wr_idx, wr_way_en, wr_coh_state, wr_tag,
        input  rd_ready, wr_ready,
        input  resp_valid, resp_id, resp_way_tag, resp_way_coh,
        input  resp_hit_way, resp_hit, init_done
    );

    modport slave (
        input  rd_valid, rd_idx, rd_tag,
        input  wr_valid, wr_idx, wr_way_en, wr_coh_state, wr_tag,
        output rd_ready, wr_ready,
        output resp_valid, resp_id, resp_way_tag, resp_way_coh,
        output resp_hit_way, resp_hit, init_done
    );
endinterface

// File: rtl/l1_meta_array_ctrl.sv
// L1 data-cache metadata array (tag + coherence state per way) with fixed-priority
// read/write arbitration, post-reset invalidation sweep and 1-cycle read response.
//
// state   | meaning
// INIT    | sweeping one set per cycle to tag=0/coh=0; all readies held low
// RUN     | one array access per cycle, writes beat reads
module l1_meta_array_ctrl #(
    parameter int NRD   = 4,
    parameter int NWR   = 2,
    parameter int NSETS = 64,
    parameter int NWAYS = 8,
    parameter int TAGW  = 20
) (
    input logic                  clk_i,
    input logic                  rst_i,
    l1_meta_array_ctrl_if.slave  bus
);
    localparam int IDXW = $clog2(NSETS);
    localparam int IDW  = (NRD > 1) ? $clog2(NRD) : 1;
    localparam int WSW  = (NWR > 1) ? $clog2(NWR) : 1;
    localparam int CW   = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] sweep_q, sweep_d;
    logic            init_done_q, init_done_d;

    logic [TAGW-1:0] tag_mem [NSETS][NWAYS];
    logic [CW-1:0]   coh_mem [NSETS][NWAYS];

    logic            wr_any, rd_any;
    logic [WSW-1:0]  wr_sel;
    logic [IDW-1:0]  rd_sel;
    logic [NWR-1:0]  wr_gnt;
    logic [NRD-1:0]  rd_gnt;

    logic [IDXW-1:0]  wr_idx_s, rd_idx_s;
    logic [NWAYS-1:0] wr_en_s;
    logic [CW-1:0]    wr_coh_s;
    logic [TAGW-1:0]  wr_tag_s, rd_tag_s;

    logic            resp_valid_q;
    logic [IDW-1:0]  resp_id_q;
    logic [TAGW-1:0] resp_tag_q [NWAYS];
    logic [CW-1:0]   resp_coh_q [NWAYS];
    logic [TAGW-1:0] req_tag_q;
    logic [NWAYS-1:0] hit_way;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == IDXW'(NSETS - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Fixed priority, lowest index wins; grants depend only on the valid vectors.
    always_comb begin
        wr_any = 1'b0;
        rd_any = 1'b0;
        wr_sel = '0;
        rd_sel = '0;
        wr_gnt = '0;
        rd_gnt = '0;
        if (state_q == ST_RUN) begin
            for (int i = NWR - 1; i >= 0; i--) begin
                if (bus.wr_valid[i]) begin
                    wr_any = 1'b1;
                    wr_sel = WSW'(i);
                end
            end
            if (wr_any) begin
                wr_gnt[wr_sel] = 1'b1;
            end else begin
                for (int i = NRD - 1; i >= 0; i--) begin
                    if (bus.rd_valid[i]) begin
                        rd_any = 1'b1;
                        rd_sel = IDW'(i);
                    end
                end
                if (rd_any) begin
                    rd_gnt[rd_sel] = 1'b1;
                end
            end
        end
    end

    assign wr_idx_s = bus.wr_idx[int'(wr_sel)*IDXW +: IDXW];
    assign wr_en_s  = bus.wr_way_en[int'(wr_sel)*NWAYS +: NWAYS];
    assign wr_coh_s = bus.wr_coh_state[int'(wr_sel)*CW +: CW];
    assign wr_tag_s = bus.wr_tag[int'(wr_sel)*TAGW +: TAGW];
    assign rd_idx_s = bus.rd_idx[int'(rd_sel)*IDXW +: IDXW];
    assign rd_tag_s = bus.rd_tag[int'(rd_sel)*TAGW +: TAGW];

    assign bus.wr_ready = wr_gnt;
    assign bus.rd_ready = rd_gnt;

    // Sweep and granted writes share the single write port; FSM state keeps them exclusive.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            for (int w = 0; w < NWAYS; w++) begin
                tag_mem[sweep_q][w] <= '0;
                coh_mem[sweep_q][w] <= '0;
            end
        end else if (wr_any) begin
            for (int w = 0; w < NWAYS; w++) begin
                if (wr_en_s[w]) begin
                    tag_mem[wr_idx_s][w] <= wr_tag_s;
                    coh_mem[wr_idx_s][w] <= wr_coh_s;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
        end else begin
            resp_valid_q <= rd_any;
            if (rd_any) begin
                resp_id_q <= rd_sel;
            end
        end
    end

    // Payload needs no reset: it is only observed alongside resp_valid.
    always_ff @(posedge clk_i) begin
        if (rd_any) begin
            req_tag_q <= rd_tag_s;
            for (int w = 0; w < NWAYS; w++) begin
                resp_tag_q[w] <= tag_mem[rd_idx_s][w];
                resp_coh_q[w] <= coh_mem[rd_idx_s][w];
            end
        end
    end

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < NWAYS; w++) begin
            hit_way[w] = (resp_tag_q[w] == req_tag_q) && (resp_coh_q[w] != '0);
        end
    end

    for (genvar w = 0; w < NWAYS; w++) begin : g_pack
        assign bus.resp_way_tag[w*TAGW +: TAGW] = resp_tag_q[w];
        assign bus.resp_way_coh[w*CW +: CW]     = resp_coh_q[w];
    end

    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_hit_way = hit_way;
    assign bus.resp_hit     = |hit_way;
    assign bus.init_done    = init_done_q;
endmodule

// File: tb/tb_l1_meta_array_ctrl.sv
// Self-checking bench for l1_meta_array_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a behavioural model.
module tb_l1_meta_array_ctrl;
    localparam int NRD = 4, NWR = 2, NSETS = 64, NWAYS = 8, TAGW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1_meta_array_ctrl_if #(.NRD(NRD), .NWR(NWR), .NSETS(NSETS), .NWAYS(NWAYS), .TAGW(TAGW)) bus ();

    l1_meta_array_ctrl #(.NRD(NRD), .NWR(NWR), .NSETS(NSETS), .NWAYS(NWAYS), .TAGW(TAGW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: array contents, cycles since reset, pending response.
    logic [19:0] m_tag [NSETS][NWAYS];
    logic [1:0]  m_coh [NSETS][NWAYS];
    int          cyc = 0;
    bit          pend = 0;
    int          p_id;
    logic [19:0] p_tag [NWAYS];
    logic [1:0]  p_coh [NWAYS];
    logic [19:0] p_req;

    always @(negedge clk) begin : model
        bit             run;
        int             wsel, rsel, idx;
        logic [NWR-1:0] ew;
        logic [NRD-1:0] er;
        logic [159:0]   etag;
        logic [15:0]    ecoh;
        logic [7:0]     ehit;
        logic [7:0]     en;

        run  = (cyc >= NSETS);
        ew   = '0;
        er   = '0;
        wsel = -1;
        rsel = -1;
        if (run) begin
            for (int i = 0; i < NWR; i++) if (bus.wr_valid[i] && wsel < 0) wsel = i;
            if (wsel >= 0) ew[wsel] = 1'b1;
            else begin
                for (int i = 0; i < NRD; i++) if (bus.rd_valid[i] && rsel < 0) rsel = i;
                if (rsel >= 0) er[rsel] = 1'b1;
            end
        end
        chk("wr_ready", bus.wr_ready, ew);
        chk("rd_ready", bus.rd_ready, er);
        chk("init_done", bus.init_done, run);
        chk("resp_valid", bus.resp_valid, pend);
        if (pend) begin
            ehit = '0;
            for (int w = 0; w < NWAYS; w++) begin
                etag[w*20 +: 20] = p_tag[w];
                ecoh[w*2 +: 2]   = p_coh[w];
                ehit[w]          = (p_tag[w] == p_req) && (p_coh[w] != 2'b00);
            end
            chk("resp_id", bus.resp_id, p_id);
            chk("resp_way_tag", bus.resp_way_tag, etag);
            chk("resp_way_coh", bus.resp_way_coh, ecoh);
            chk("resp_hit_way", bus.resp_hit_way, ehit);
            chk("resp_hit", bus.resp_hit, |ehit);
        end

        pend = 0;
        if (rst) begin
            cyc = 0;
            for (int s = 0; s < NSETS; s++)
                for (int w = 0; w < NWAYS; w++) begin
                    m_tag[s][w] = '0;
                    m_coh[s][w] = '0;
                end
        end else begin
            if (wsel >= 0) begin
                idx = int'(bus.wr_idx[wsel*6 +: 6]);
                en  = bus.wr_way_en[wsel*8 +: 8];
                for (int w = 0; w < NWAYS; w++) if (en[w]) begin
                    m_tag[idx][w] = bus.wr_tag[wsel*20 +: 20];
                    m_coh[idx][w] = bus.wr_coh_state[wsel*2 +: 2];
                end
            end else if (rsel >= 0) begin
                idx   = int'(bus.rd_idx[rsel*6 +: 6]);
                pend  = 1;
                p_id  = rsel;
                p_req = bus.rd_tag[rsel*20 +: 20];
                for (int w = 0; w < NWAYS; w++) begin
                    p_tag[w] = m_tag[idx][w];
                    p_coh[w] = m_coh[idx][w];
                end
            end
            if (cyc < 1000000) cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int p, input int idx, input logic [7:0] en,
                            input logic [19:0] tag, input logic [1:0] coh);
        logic got;
        bus.wr_valid[p]           = 1'b1;
        bus.wr_idx[p*6 +: 6]      = 6'(idx);
        bus.wr_way_en[p*8 +: 8]   = en;
        bus.wr_tag[p*20 +: 20]    = tag;
        bus.wr_coh_state[p*2 +: 2] = coh;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = bus.wr_ready[p];
            tick();
        end
        chk("wr_grant_wait", got, 1'b1);
        bus.wr_valid[p] = 1'b0;
    endtask

    // Returns the response fields sampled the cycle after the grant.
    task automatic do_read(input int p, input int idx, input logic [19:0] tag,
                           output logic [7:0] hitw, output logic hit,
                           output logic [159:0] tags, output logic [15:0] cohs);
        logic got;
        bus.rd_valid[p]        = 1'b1;
        bus.rd_idx[p*6 +: 6]   = 6'(idx);
        bus.rd_tag[p*20 +: 20] = tag;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = bus.rd_ready[p];
            tick();
        end
        chk("rd_grant_wait", got, 1'b1);
        bus.rd_valid[p] = 1'b0;
        @(negedge clk);
        chk("rd_resp_valid", bus.resp_valid, 1'b1);
        hitw = bus.resp_hit_way;
        hit  = bus.resp_hit;
        tags = bus.resp_way_tag;
        cohs = bus.resp_way_coh;
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0]     hitw;
        logic           hit;
        logic [159:0]   tags;
        logic [15:0]    cohs;
        logic [NRD-1:0] rg;
        logic [NWR-1:0] wg;

        bus.rd_valid = '0; bus.rd_idx = '0; bus.rd_tag = '0;
        bus.wr_valid = '0; bus.wr_idx = '0; bus.wr_way_en = '0;
        bus.wr_coh_state = '0; bus.wr_tag = '0;
        repeat (3) tick();

        // Sweep timing with a reader waiting from the first cycle.
        bus.rd_valid[0] = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0 || k == 63) begin
                chk("init_rd_ready", bus.rd_ready, 4'b0000);
                chk("init_done_low", bus.init_done, 1'b0);
            end
            tick();
        end
        @(negedge clk);
        chk("first_grant", bus.rd_ready, 4'b0001);
        chk("init_done_64", bus.init_done, 1'b1);
        tick();
        bus.rd_valid[0] = 1'b0;
        @(negedge clk);
        chk("first_resp_valid", bus.resp_valid, 1'b1);
        chk("first_resp_coh", bus.resp_way_coh, 16'h0000);
        chk("first_resp_hit", bus.resp_hit, 1'b0);
        tick();

        // Single-way write then hit / miss reads.
        do_write(0, 5, 8'h04, 20'hABCDE, 2'b11);
        do_read(0, 5, 20'hABCDE, hitw, hit, tags, cohs);
        chk("hit_way_5", hitw, 8'h04);
        chk("hit_5", hit, 1'b1);
        chk("way2_tag_5", tags[59:40], 20'hABCDE);
        do_read(1, 5, 20'hABCDF, hitw, hit, tags, cohs);
        chk("miss_5", hit, 1'b0);

        // Write beats reads in the same cycle, then readers in priority order.
        bus.wr_valid[1] = 1'b1; bus.wr_idx[11:6] = 6'd7; bus.wr_way_en[15:8] = 8'hFF;
        bus.wr_tag[39:20] = 20'h77777; bus.wr_coh_state[3:2] = 2'b01;
        bus.rd_valid[0] = 1'b1; bus.rd_idx[5:0] = 6'd7; bus.rd_tag[19:0] = 20'h77777;
        bus.rd_valid[2] = 1'b1; bus.rd_idx[17:12] = 6'd3; bus.rd_tag[59:40] = 20'h00000;
        @(negedge clk);
        chk("mix_wr_ready", bus.wr_ready, 2'b10);
        chk("mix_rd_ready0", bus.rd_ready, 4'b0000);
        tick();
        bus.wr_valid[1] = 1'b0;
        @(negedge clk);
        chk("mix_rd_ready1", bus.rd_ready, 4'b0001);
        tick();
        bus.rd_valid[0] = 1'b0;
        @(negedge clk);
        chk("mix_rd_ready2", bus.rd_ready, 4'b0100);
        chk("mix_resp_id0", bus.resp_id, 2'd0);
        chk("mix_new_data", bus.resp_hit_way, 8'hFF);
        tick();
        bus.rd_valid[2] = 1'b0;
        @(negedge clk);
        chk("mix_resp_id2", bus.resp_id, 2'd2);
        tick();

        // Invalidating write leaves the tag but kills the hit.
        do_write(0, 9, 8'h01, 20'h12345, 2'b10);
        do_write(1, 9, 8'h01, 20'h12345, 2'b00);
        do_read(3, 9, 20'h12345, hitw, hit, tags, cohs);
        chk("inval_hit", hit, 1'b0);
        chk("inval_tag", tags[19:0], 20'h12345);

        // All readers valid: reader 0 keeps winning until it drops.
        bus.rd_valid = 4'b1111;
        for (int i = 0; i < NRD; i++) bus.rd_idx[i*6 +: 6] = 6'(i + 20);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("starve_rd_ready", bus.rd_ready, 4'b0001);
            if (k > 0) chk("b2b_resp_valid", bus.resp_valid, 1'b1);
            tick();
        end
        bus.rd_valid[0] = 1'b0;
        @(negedge clk);
        chk("drop0_rd_ready", bus.rd_ready, 4'b0010);
        chk("drop0_resp_valid", bus.resp_valid, 1'b1);
        tick();
        bus.rd_valid = '0;
        tick();

        // Randomized traffic; requesters hold their fields until granted.
        rg = '0;
        wg = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NRD; i++) begin
                if (!bus.rd_valid[i] || rg[i]) begin
                    bus.rd_valid[i]        = ($urandom_range(0, 1) == 1);
                    bus.rd_idx[i*6 +: 6]   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                                         : 6'($urandom_range(0, 3));
                    bus.rd_tag[i*20 +: 20] = 20'h10000 + 20'($urandom_range(0, 3));
                end
            end
            for (int j = 0; j < NWR; j++) begin
                if (!bus.wr_valid[j] || wg[j]) begin
                    bus.wr_valid[j]            = ($urandom_range(0, 4) == 0);
                    bus.wr_idx[j*6 +: 6]       = 6'($urandom_range(0, 3));
                    bus.wr_way_en[j*8 +: 8]    = 8'($urandom_range(0, 255));
                    bus.wr_tag[j*20 +: 20]     = 20'h10000 + 20'($urandom_range(0, 3));
                    bus.wr_coh_state[j*2 +: 2] = 2'($urandom_range(0, 3));
                end
            end
            @(negedge clk);
            rg = bus.rd_ready;
            wg = bus.wr_ready;
            tick();
        end
        bus.rd_valid = '0;
        bus.wr_valid = '0;
        tick();

        // Re-establish a known line, then reset in the cycle of a read grant.
        do_write(0, 5, 8'h04, 20'hABCDE, 2'b11);
        repeat (10) tick();
        bus.rd_valid[0] = 1'b1; bus.rd_idx[5:0] = 6'd5; bus.rd_tag[19:0] = 20'hABCDE;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_grant", bus.rd_ready, 4'b0001);
        tick();
        rst = 1'b0;
        bus.rd_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_no_resp", bus.resp_valid, 1'b0);
        chk("rst_init_drop", bus.init_done, 1'b0);
        repeat (63) tick();
        @(negedge clk);
        chk("resweep_63", bus.init_done, 1'b0);
        tick();
        @(negedge clk);
        chk("resweep_64", bus.init_done, 1'b1);
        tick();
        do_read(0, 5, 20'hABCDE, hitw, hit, tags, cohs);
        chk("resweep_coh", cohs[5:4], 2'b00);
        chk("resweep_hit", hit, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/l1_meta_array_ctrl.md
Name: l1_meta_array_ctrl

Overview:
Owns the L1 data-cache metadata array: 64 sets x 8 ways, each way holding a 20-bit tag and a 2-bit coherence state. It arbitrates NRD read requesters (pipeline, MSHR replay, probe unit, writeback unit) and NWR write requesters onto the single-ported array, and returns per-way tags plus a hit vector one cycle after each read grant. After reset it sweeps every set to invalid before accepting traffic.

Parameters:
NRD, 4, number of read requesters; index 0 has highest priority
NWR, 2, number of write requesters; index 0 has highest priority
NSETS, 64, sets; idx width = log2(NSETS) = 6
NWAYS, 8, ways; way_en width
TAGW, 20, tag width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
rd_valid  in  NRD  per-requester read request
rd_ready  out  NRD  per-requester read grant
rd_idx  in  NRD*6  set index, requester i at bits [6i+5:6i]
rd_tag  in  NRD*20  compare tag, requester i at bits [20i+19:20i]
wr_valid  in  NWR  per-requester write request
wr_ready  out  NWR  per-requester write grant
wr_idx  in  NWR*6  set index
wr_way_en  in  NWR*8  one-hot or multi-hot ways to write
wr_coh_state  in  NWR*2  coherence state to write (0 = invalid)
wr_tag  in  NWR*20  tag to write
resp_valid  out  1  read response valid
resp_id  out  log2(NRD)  requester that owns the response
resp_way_tag  out  8*20  stored tags, way w at bits [20w+19:20w]
resp_way_coh  out  8*2  stored coh states
resp_hit_way  out  8  way w set iff stored tag == request tag and coh != 0
resp_hit  out  1  OR of resp_hit_way
init_done  out  1  high once the sweep completes

Behaviour:
- Reset values: all rd_ready/wr_ready = 0, resp_valid = 0, resp_id = 0, init_done = 0, FSM = INIT, sweep counter = 0. Array contents are undefined until the sweep completes.
- FSM INIT:
  - Each cycle writes tag = 0 and coh = 0 to all 8 ways of set sweep counter, then increments the counter.
  - On the cycle the set-63 write occurs, transition to RUN. init_done rises the following cycle, which is 64 cycles after reset deasserts.
  - All readies are 0 during INIT; requests stay pending.
- FSM RUN, one array access per cycle:
  - If any wr_valid is set, the lowest-index valid writer gets wr_ready = 1 (combinational from wr_valid) and the write commits at the clock edge. All rd_ready are 0 that cycle.
  - Otherwise, the lowest-index valid reader gets rd_ready = 1 and the array is read.
  - Writes always beat reads. Readers may starve under continuous writes; that is accepted.
  - The write updates only ways with wr_way_en = 1. wr_way_en = 0 is still a granted no-op.
- Read response:
  - Exactly 1 cycle after the rd handshake, resp_valid = 1 with resp_id, the way tags/coh, and the hit vector computed against the registered request tag.
  - There is no backpressure; consumers must accept.
  - A read granted the cycle after a write to the same set observes the new data.
  - Back-to-back reads give back-to-back responses.
- Requester i must hold idx/tag stable while valid and not ready. Readiness does not depend on other requesters' data fields.
- Multiple stored ways matching the tag: resp_hit_way reports all of them. Preventing duplicates is the writers' responsibility.
- Reset in RUN or mid-INIT:
  - Next cycle FSM = INIT with counter = 0, resp_valid = 0, init_done = 0.
  - The full sweep repeats.
  - A read granted in the reset cycle produces no response.
- Array: flop- or SRAM-based with a 1-cycle registered read. Only one access per cycle.

Test Plan:
- Release reset, hold rd_valid[0] = 1 -> rd_ready stays 0 for cycles 0..63; init_done = 1 at cycle 64; first grant at cycle 64; response at cycle 65 with resp_way_coh = 0 and resp_hit = 0.
- After init:
  - Write idx=5, way_en=8'h04, tag=20'hABCDE, coh=2'b11.
  - Read idx=5, tag=20'hABCDE -> resp_hit_way = 8'h04, resp_hit = 1, tag for way 2 = 20'hABCDE.
  - Read idx=5, tag=20'hABCDF -> resp_hit = 0.
- Same cycle: wr_valid[1] with rd_valid[0] and rd_valid[2] -> wr_ready = 2'b10 and rd_ready = 0. Next cycle rd_ready = 4'b0001; the cycle after, rd_ready = 4'b0100. Responses carry resp_id 0 then 2, and the read to the written set returns the new data.
- Write idx=9 coh=0 over a valid line, then read with the old tag -> resp_hit = 0 even though the stored tag still matches.
- All 4 readers valid for 4 cycles with no writes -> grants in order 0,0,0,0 while reader 0 stays valid; drop reader 0 -> reader 1 is granted next. resp_valid stays high every cycle.
- Assert reset 10 cycles into RUN, in the same cycle as a read grant -> no resp_valid follows; init_done drops; the sweep re-runs 64 cycles; a previously written line reads back coh = 0.
